// File: rtl/cond_pkg.sv
// Shared condition-code and flag definitions for the condition/flag unit.
// Flags are packed {V,C,Z,N} in bits [3:0].
package cond_pkg;

  localparam logic [3:0] COND_EQ = 4'd0;
  localparam logic [3:0] COND_NE = 4'd1;
  localparam logic [3:0] COND_CS = 4'd2;
  localparam logic [3:0] COND_CC = 4'd3;
  localparam logic [3:0] COND_MI = 4'd4;
  localparam logic [3:0] COND_PL = 4'd5;
  localparam logic [3:0] COND_VS = 4'd6;
  localparam logic [3:0] COND_VC = 4'd7;
  localparam logic [3:0] COND_HI = 4'd8;
  localparam logic [3:0] COND_LS = 4'd9;
  localparam logic [3:0] COND_GE = 4'd10;
  localparam logic [3:0] COND_LT = 4'd11;
  localparam logic [3:0] COND_GT = 4'd12;
  localparam logic [3:0] COND_LE = 4'd13;
  localparam logic [3:0] COND_AL = 4'd14;
  localparam logic [3:0] COND_NV = 4'd15;

  localparam int FLG_N = 0;
  localparam int FLG_Z = 1;
  localparam int FLG_C = 2;
  localparam int FLG_V = 3;

  function automatic logic cond_eval(input logic [3:0] cond,
                                     input logic [3:0] flags,
                                     input logic       nv_pass);
    logic n, z, c, v, r;
    n = flags[FLG_N];
    z = flags[FLG_Z];
    c = flags[FLG_C];
    v = flags[FLG_V];
    r = 1'b0;
    case (cond)
      COND_EQ: r = z;
      COND_NE: r = ~z;
      COND_CS: r = c;
      COND_CC: r = ~c;
      COND_MI: r = n;
      COND_PL: r = ~n;
      COND_VS: r = v;
      COND_VC: r = ~v;
      COND_HI: r = c & ~z;
      COND_LS: r = ~c | z;
      COND_GE: r = (n == v);
      COND_LT: r = (n != v);
      COND_GT: r = ~z & (n == v);
      COND_LE: r = z | (n != v);
      COND_AL: r = 1'b1;
      default: r = nv_pass;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cond_flag_unit_flag_stack.sv
// Bounded LIFO of saved flag values with occupancy count.
// Illegal requests (overflow, underflow, push+pop together) leave the stack untouched and pulse err_set.
module flag_stack #(
  parameter int DEPTH = 4,
  parameter int DW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [3:0]    din,
  output logic [3:0]    top,
  output logic [DW-1:0] depth,
  output logic          pop_ok,
  output logic          err_set
);

  logic [3:0] mem [DEPTH];
  logic       push_only, pop_only;
  logic       full, empty, push_ok;

  assign push_only = push & ~pop;
  assign pop_only  = pop & ~push;
  assign full      = (depth == DW'(DEPTH));
  assign empty     = (depth == '0);
  assign push_ok   = push_only & ~full;
  assign pop_ok    = pop_only & ~empty;
  assign err_set   = (push & pop) | (push_only & full) | (pop_only & empty);

  // Top of stack lives at index depth-1.
  always_comb begin
    top = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (depth == DW'(i + 1)) top = mem[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      depth <= '0;
    end else if (push_ok) begin
      depth <= depth + DW'(1);
    end else if (pop_ok) begin
      depth <= depth - DW'(1);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (push_ok && depth == DW'(i)) mem[i] <= din;
    end
  end

endmodule

// File: rtl/cond_flag_unit.sv
// NZCV flag register with masked writes, shadow stack and LANES registered condition checks.
// Query-to-result latency is one cycle; no backpressure.
module cond_flag_unit
  import cond_pkg::*;
#(
  parameter int LANES   = 2,
  parameter int DEPTH   = 4,
  parameter int BYPASS  = 1,
  parameter int NV_PASS = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flag_we,
  input  logic [3:0]                   flag_mask,
  input  logic [3:0]                   flag_in,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         err_clr,
  input  logic [LANES-1:0]             chk_valid,
  input  logic [4*LANES-1:0]           chk_cond,
  output logic [LANES-1:0]             pass,
  output logic [LANES-1:0]             pass_valid,
  output logic [3:0]                   flags,
  output logic [$clog2(DEPTH+1)-1:0]   stk_depth,
  output logic                         stk_err
);

  localparam int  DW    = $clog2(DEPTH + 1);
  localparam logic NV_R = (NV_PASS != 0);

  logic [3:0]       stk_top;
  logic             stk_pop_ok;
  logic             stk_err_set;
  logic [3:0]       flags_nxt;
  logic [3:0]       eval_flags;
  logic [LANES-1:0] pass_d;

  // The stack always saves the register value, i.e. before any same-cycle write.
  flag_stack #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_stack (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (pop),
    .din     (flags),
    .top     (stk_top),
    .depth   (stk_depth),
    .pop_ok  (stk_pop_ok),
    .err_set (stk_err_set)
  );

  always_comb begin
    flags_nxt = flags;
    if (stk_pop_ok) begin
      flags_nxt = stk_top;
    end else if (flag_we) begin
      flags_nxt = (flags & ~flag_mask) | (flag_in & flag_mask);
    end
  end

  assign eval_flags = (BYPASS != 0) ? flags_nxt : flags;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign pass_d[g] = chk_valid[g] & cond_eval(chk_cond[4*g +: 4], eval_flags, NV_R);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags      <= '0;
      stk_err    <= 1'b0;
      pass       <= '0;
      pass_valid <= '0;
    end else begin
      flags      <= flags_nxt;
      pass       <= pass_d;
      pass_valid <= chk_valid;
      if (stk_err_set) begin
        stk_err <= 1'b1;
      end else if (err_clr) begin
        stk_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cond_flag_unit.sv
// Scoreboarded bench: a bypassing and a non-bypassing instance share stimulus and a reference model.
module tb_cond_flag_unit;

  logic       clk;
  logic       rst_n;
  logic       flag_we;
  logic [3:0] flag_mask;
  logic [3:0] flag_in;
  logic       push, pop, err_clr;
  logic [1:0] chk_valid;
  logic [7:0] chk_cond;

  logic [1:0] pass_b, pv_b, pass_n, pv_n;
  logic [3:0] flags_b, flags_n;
  logic [2:0] dp_b, dp_n;
  logic       err_b, err_n;

  typedef struct packed {
    logic [1:0] pb;
    logic [1:0] pn;
    logic [1:0] pv;
    logic [3:0] fl;
    logic [2:0] dp;
    logic       er;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] m_stk[$];
  logic [3:0] m_flags;
  logic       m_err;
  int         total, bad;

  cond_flag_unit #(.LANES(2), .DEPTH(4), .BYPASS(1), .NV_PASS(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .flag_we(flag_we), .flag_mask(flag_mask), .flag_in(flag_in),
    .push(push), .pop(pop), .err_clr(err_clr), .chk_valid(chk_valid), .chk_cond(chk_cond),
    .pass(pass_b), .pass_valid(pv_b), .flags(flags_b), .stk_depth(dp_b), .stk_err(err_b)
  );

  cond_flag_unit #(.LANES(2), .DEPTH(4), .BYPASS(0), .NV_PASS(0)) u_dut_nb (
    .clk(clk), .rst_n(rst_n), .flag_we(flag_we), .flag_mask(flag_mask), .flag_in(flag_in),
    .push(push), .pop(pop), .err_clr(err_clr), .chk_valid(chk_valid), .chk_cond(chk_cond),
    .pass(pass_n), .pass_valid(pv_n), .flags(flags_n), .stk_depth(dp_n), .stk_err(err_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Even codes test a base predicate; odd codes are its complement.
  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    n = f[0]; z = f[1]; cy = f[2]; v = f[3];
    case (c[3:1])
      3'd0:    base = z;
      3'd1:    base = cy;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = cy & ~z;
      3'd5:    base = (n == v);
      3'd6:    base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    if (c == 4'd15) return 1'b0;
    if (c == 4'd14) return 1'b1;
    return base ^ c[0];
  endfunction

  task automatic idle();
    flag_we = 0; flag_mask = 4'h0; flag_in = 4'h0;
    push = 0; pop = 0; err_clr = 0; chk_valid = 2'b00; chk_cond = 8'h00;
  endtask

  task automatic model_reset();
    m_flags = 4'h0;
    m_err   = 1'b0;
    m_stk.delete();
    sb.delete();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_pass"},   32'(pass_b) | 32'(pass_n), 32'd0);
    chk({tag, "_pvalid"}, 32'(pv_b) | 32'(pv_n),     32'd0);
    chk({tag, "_flags"},  32'(flags_b) | 32'(flags_n), 32'd0);
    chk({tag, "_depth"},  32'(dp_b) | 32'(dp_n),     32'd0);
    chk({tag, "_err"},    32'(err_b) | 32'(err_n),   32'd0);
  endtask

  // Predict this cycle from the current inputs, clock it, then compare.
  task automatic step();
    exp_t       e, o;
    logic [3:0] pre, nf;
    logic       pu, po, eset;
    pre  = m_flags;
    pu   = push & ~pop;
    po   = pop & ~push;
    eset = (push & pop) | (pu && m_stk.size() == 4) | (po && m_stk.size() == 0);
    nf   = pre;
    if (po && m_stk.size() > 0) nf = m_stk.pop_back();
    else if (flag_we) nf = (pre & ~flag_mask) | (flag_in & flag_mask);
    if (pu && m_stk.size() < 4) m_stk.push_back(pre);
    if (eset) m_err = 1'b1;
    else if (err_clr) m_err = 1'b0;
    for (int i = 0; i < 2; i++) begin
      e.pb[i] = chk_valid[i] & ref_cond(chk_cond[4*i +: 4], nf);
      e.pn[i] = chk_valid[i] & ref_cond(chk_cond[4*i +: 4], pre);
    end
    e.pv    = chk_valid;
    e.fl    = nf;
    e.dp    = 3'(m_stk.size());
    e.er    = m_err;
    m_flags = nf;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      o = sb.pop_front();
      chk("pass_byp",   32'(pass_b),  32'(o.pb));
      chk("pass_nobyp", 32'(pass_n),  32'(o.pn));
      chk("pvalid_byp", 32'(pv_b),    32'(o.pv));
      chk("pvalid_nb",  32'(pv_n),    32'(o.pv));
      chk("flags_byp",  32'(flags_b), 32'(o.fl));
      chk("flags_nb",   32'(flags_n), 32'(o.fl));
      chk("depth",      32'(dp_b),    32'(o.dp));
      chk("depth_nb",   32'(dp_n),    32'(o.dp));
      chk("err",        32'(err_b),   32'(o.er));
      chk("err_nb",     32'(err_n),   32'(o.er));
    end
  endtask

  logic [3:0] q4[4];
  logic       e4[4];

  initial begin
    total = 0; bad = 0;
    idle();
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // EQ, NE, AL, NV on cleared flags
    q4 = '{4'd0, 4'd1, 4'd14, 4'd15};
    e4 = '{1'b0, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 4; k++) begin
      idle(); chk_valid = 2'b01; chk_cond = {4'd0, q4[k]};
      step();
      chk("tp_basic", 32'(pass_b[0]), 32'(e4[k]));
      chk("tp_basic_v", 32'(pv_b[0]), 32'd1);
    end

    // Same-cycle write with LS (lane 0) and HI (lane 1)
    idle(); flag_we = 1; flag_mask = 4'hF; flag_in = 4'b0110;
    chk_valid = 2'b11; chk_cond = {4'd8, 4'd9};
    step();
    chk("tp_hazard_byp", 32'(pass_b), 32'b01);
    chk("tp_hazard_nb",  32'(pass_n), 32'b01);
    idle(); chk_valid = 2'b11; chk_cond = {4'd8, 4'd8};
    step();
    chk("tp_hi_next", 32'(pass_b) | 32'(pass_n), 32'd0);

    // N=1: LE / GT, then set Z alone
    idle(); flag_we = 1; flag_mask = 4'hF; flag_in = 4'b0001;
    step();
    idle(); chk_valid = 2'b11; chk_cond = {4'd12, 4'd13};
    step();
    chk("tp_le_gt", 32'(pass_b), 32'b01);
    flag_we = 1; flag_mask = 4'b0010; flag_in = 4'b0010;
    step();
    chk("tp_le_gt_z", 32'(pass_b), 32'b01);
    chk("tp_mask_z", 32'(flags_b), 32'b0011);

    // Fill the stack while writing between pushes
    idle(); flag_we = 1; flag_mask = 4'hF; flag_in = 4'b0001;
    step();
    q4 = '{4'b0010, 4'b0100, 4'b1000, 4'b0000};
    for (int k = 0; k < 4; k++) begin
      idle(); push = 1; flag_we = (k < 3); flag_mask = 4'hF; flag_in = q4[k];
      step();
    end
    chk("tp_full", 32'(dp_b), 32'd4);
    idle(); push = 1;
    step();
    chk("tp_overflow_err", 32'(err_b), 32'd1);
    chk("tp_overflow_dp",  32'(dp_b),  32'd4);
    q4 = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
    for (int k = 0; k < 4; k++) begin
      idle(); pop = 1;
      step();
      chk("tp_pop_order", 32'(flags_b), 32'(q4[k]));
    end
    idle(); pop = 1;
    step();
    chk("tp_underflow_fl",  32'(flags_b), 32'b0001);
    chk("tp_underflow_err", 32'(err_b),   32'd1);
    idle(); err_clr = 1;
    step();
    chk("tp_err_clr", 32'(err_b), 32'd0);

    // Push+pop together with a write
    idle(); push = 1;
    step();
    idle(); push = 1; pop = 1; flag_we = 1; flag_mask = 4'hF; flag_in = 4'hF;
    step();
    chk("tp_pp_dp",  32'(dp_b),    32'd1);
    chk("tp_pp_fl",  32'(flags_b), 32'hF);
    chk("tp_pp_err", 32'(err_b),   32'd1);
    idle(); err_clr = 1;
    step();

    // Random traffic
    for (int k = 0; k < 300; k++) begin
      flag_we   = 1'($urandom_range(0, 1));
      flag_mask = 4'($urandom);
      flag_in   = 4'($urandom);
      push      = ($urandom_range(0, 7) == 0);
      pop       = ($urandom_range(0, 7) == 0);
      err_clr   = ($urandom_range(0, 15) == 0);
      chk_valid = 2'($urandom);
      chk_cond  = 8'($urandom);
      step();
    end

    // Reset in the middle of operation with three stacked entries
    for (int k = 0; k < 8 && m_stk.size() > 0; k++) begin
      idle(); pop = 1;
      step();
    end
    for (int k = 0; k < 3; k++) begin
      idle(); push = 1; flag_we = 1; flag_mask = 4'hF; flag_in = 4'b0101;
      step();
    end
    chk("tp_depth3", 32'(dp_b), 32'd3);
    idle(); chk_valid = 2'b11; chk_cond = {4'd14, 4'd14};
    step();
    chk("tp_inflight", 32'(pass_b), 32'b11);
    rst_n = 1'b0;
    #1;
    check_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    idle(); pop = 1; chk_valid = 2'b11; chk_cond = {4'd1, 4'd0};
    step();
    chk("tp_post_err",  32'(err_b),   32'd1);
    chk("tp_post_fl",   32'(flags_b), 32'd0);
    chk("tp_post_pass", 32'(pass_b),  32'b10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cond_flag_unit.md
# cond_flag_unit

Parametrised successor to the single-lane condition checker. It holds the architectural NZCV flag register and accepts masked flag writes. It saves and restores flags on a bounded shadow stack for exception entry and return. It evaluates all 16 ARM condition codes for LANES independent issue slots per cycle, and registers each pass/fail result. It sits between the ALU flag outputs and the issue/retire logic of the core pipeline.

## Interface
Parameters:
- LANES, 2: number of condition queries evaluated per cycle (1..4).
- DEPTH, 4: shadow flag stack entries (1..8).
- BYPASS, 1: 1 = queries see flags written in the same cycle; 0 = queries see the registered flags.
- NV_PASS, 0: result for cond 4'd15. 0 = never; 1 = always (legacy behaviour).

Ports:
- CLK, in, 1: single clock, rising edge.
- RESET_N, in, 1: asynchronous, active-low reset.
- FLAG_WE, in, 1: flag write strobe.
- FLAG_MASK, in, 4: per-bit write enable for FLAG_IN.
- FLAG_IN, in, 4: new flags, packed {V,C,Z,N} as bits [3:0].
- PUSH, in, 1: save the current flags to the stack.
- POP, in, 1: restore the flags from the stack top.
- ERR_CLR, in, 1: clears STK_ERR.
- CHK_VALID, in, LANES: query valid per lane.
- CHK_COND, in, 4*LANES: condition code; lane i uses bits [4i+3:4i].
- PASS, out, LANES: registered result per lane.
- PASS_VALID, out, LANES: registered CHK_VALID.
- FLAGS, out, 4: current flag register, same packing as FLAG_IN.
- STK_DEPTH, out, $clog2(DEPTH+1): number of occupied stack entries.
- STK_ERR, out, 1: sticky error for overflow, underflow or PUSH and POP in the same cycle.

## Operation
- Flag packing: N=bit0, Z=bit1, C=bit2, V=bit3.
- Condition codes (correct ARM semantics):
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V.
  - 8 HI C&!Z; 9 LS !C|Z; 10 GE N==V; 11 LT N!=V; 12 GT !Z&(N==V); 13 LE Z|(N!=V).
  - 14 AL 1; 15 NV = NV_PASS.
- Next-flags priority, highest first:
  - POP alone, stack not empty: flags <= stack top. FLAG_WE is ignored in that cycle.
  - FLAG_WE: for each bit b, flags[b] <= FLAG_MASK[b] ? FLAG_IN[b] : flags[b].
  - Otherwise: hold.
- PUSH alone, stack not full:
  - Pushes the pre-update flags (the register value before any same-cycle FLAG_WE).
  - STK_DEPTH +1.
- PUSH alone when STK_DEPTH==DEPTH: no push, STK_ERR <= 1. Flags are still updated by FLAG_WE.
- POP alone when STK_DEPTH==0: no flag change from the stack, STK_ERR <= 1. FLAG_WE applies normally.
- PUSH and POP in the same cycle: stack and depth unchanged, STK_ERR <= 1, FLAG_WE applies.
- STK_ERR: set has priority over ERR_CLR in the same cycle. Cleared only by ERR_CLR or reset.
- Evaluation flags:
  - BYPASS=1: the next-flags value computed above.
  - BYPASS=0: the FLAGS register.
- Lane results: PASS[i] <= CHK_VALID[i] ? cond(CHK_COND lane i, eval flags) : 0. PASS_VALID[i] <= CHK_VALID[i].
- Stack storage is a LIFO register array indexed by STK_DEPTH. Entries are not cleared on pop.

## Timing
- Reset (RESET_N low, asynchronous): FLAGS=4'b0000, STK_DEPTH=0, STK_ERR=0, PASS=0, PASS_VALID=0. Stack contents are don't-care.
- Reset asserted mid-operation discards stacked entries and any queries in flight. The first query accepted after reset release sees flags 0000.
- Flag write and push/pop results are visible on FLAGS and STK_DEPTH one cycle after the strobe edge.
- Query latency is 1 cycle: query sampled at edge k, result on PASS at k+1.
- Throughput is one query per lane per cycle, with no back-pressure.
- With BYPASS=1, a query and a FLAG_WE in the same cycle resolve against the written flags in that same result (0-cycle hazard).
- With BYPASS=0, the same pair resolves against the old flags. The write becomes visible to queries issued one cycle later.

## Structure
- Shared package cond_pkg:
  - Condition code localparams COND_EQ..COND_NV.
  - Flag bit index constants FLG_N, FLG_Z, FLG_C, FLG_V.
  - A function cond_eval(cond, flags, nv_pass) returning 1 bit.
- Sub-module flag_stack (DEPTH parameter):
  - Handles push/pop, depth count and the overflow/underflow/conflict error pulse.
  - Instantiated once.
- Lane evaluators are a generate loop calling cond_eval. No separate module is needed.

## Test plan
- Reset, then FLAGS=0000: query EQ, NE, AL, NV on 4 cycles. Required PASS 0,1,1,0 with PASS_VALID high, each 1 cycle after the query.
- FLAG_IN=4'b0110 (Z=1, C=1), mask 1111, query LS and HI in the same cycle:
  - BYPASS=1: LS=1, HI=0.
  - BYPASS=0: both resolve on 0000, giving LS=1, HI=0; then next-cycle HI=0.
- Flags N=1, V=0, Z=0, two lanes querying LE and GT: LE=1, GT=0. Then set Z=1 with mask 4'b0010: LE=1, GT=0, and N is unchanged.
- DEPTH=4:
  - Push 0001, 0010, 0100, 1000 while writing between pushes; a 5th PUSH sets STK_ERR=1 with STK_DEPTH=4.
  - Four POPs restore 1000, 0100, 0010, 0001 in order.
  - A 5th POP leaves flags at 0001; STK_ERR stays 1 until ERR_CLR.
- PUSH and POP asserted together with FLAG_WE=1, FLAG_IN=1111: STK_DEPTH unchanged, FLAGS=1111, STK_ERR=1.
- Assert RESET_N low for half a cycle with STK_DEPTH=3 and queries in flight: outputs immediately 0. After release, POP sets STK_ERR and FLAGS stays 0000.
